// File: rtl/mpu6050_i2c_responder.sv
// I2C target emulating the MPU6050 register file: pointer writes, PWR_MGMT_1 writes,
// and auto-incrementing burst reads of a coherent accelerometer snapshot.
module mpu6050_i2c_responder #(
    parameter logic [6:0] DEV_ADDR     = 7'h68,
    parameter logic [7:0] WHO_AM_I_VAL = 8'h68,
    parameter logic [7:0] PWR_RST_VAL  = 8'h40
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        scl_in,
    input  logic        sda_in,
    output logic        sda_oe,
    input  logic [15:0] accel_x,
    input  logic [15:0] accel_y,
    input  logic [15:0] accel_z,
    output logic [7:0]  pwr_mgmt_1,
    output logic        busy
);

    typedef enum logic [3:0] {
        S_IDLE, S_ADDR, S_A_ACK, S_REG, S_D_ACK,
        S_WDATA, S_RDATA, S_M_ACK, S_M_NEXT, S_WAIT
    } state_t;

    logic        scl_meta_q, scl_sync_q, scl_prev_q;
    logic        sda_meta_q, sda_sync_q, sda_prev_q;
    state_t      state_q, state_d;
    logic [3:0]  bitcnt_q, bitcnt_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  tx_q, tx_d;
    logic [7:0]  ptr_q, ptr_d;
    logic [7:0]  pwr_q, pwr_d;
    logic [47:0] shadow_q, shadow_d;
    logic        sda_oe_q, sda_oe_d;
    logic        busy_q, busy_d;
    logic        scl_high, start_ev, stop_ev, scl_rise, scl_fall;

    function automatic logic [7:0] rd_byte(input logic [7:0] a, input logic [47:0] sh,
                                           input logic [7:0] pwr);
        case (a)
            8'h3B:   rd_byte = sh[47:40];
            8'h3C:   rd_byte = sh[39:32];
            8'h3D:   rd_byte = sh[31:24];
            8'h3E:   rd_byte = sh[23:16];
            8'h3F:   rd_byte = sh[15:8];
            8'h40:   rd_byte = sh[7:0];
            8'h6B:   rd_byte = pwr;
            8'h75:   rd_byte = WHO_AM_I_VAL;
            default: rd_byte = 8'h00;
        endcase
    endfunction

    assign scl_high = scl_sync_q & scl_prev_q;
    assign start_ev = scl_high & sda_prev_q & ~sda_sync_q;
    assign stop_ev  = scl_high & ~sda_prev_q & sda_sync_q;
    assign scl_rise = scl_sync_q & ~scl_prev_q;
    assign scl_fall = ~scl_sync_q & scl_prev_q;

    always_comb begin
        state_d  = state_q;
        bitcnt_d = bitcnt_q;
        shift_d  = shift_q;
        tx_d     = tx_q;
        ptr_d    = ptr_q;
        pwr_d    = pwr_q;
        shadow_d = shadow_q;
        sda_oe_d = sda_oe_q;
        busy_d   = busy_q;
        if (stop_ev) begin
            state_d  = S_IDLE;
            sda_oe_d = 1'b0;
            busy_d   = 1'b0;
        end else if (start_ev) begin
            state_d  = S_ADDR;
            bitcnt_d = 4'd0;
            sda_oe_d = 1'b0;
            busy_d   = 1'b1;
        end else begin
            case (state_q)
                S_ADDR, S_REG, S_WDATA: begin
                    if (scl_rise && bitcnt_q != 4'd8) begin
                        shift_d  = {shift_q[6:0], sda_sync_q};
                        bitcnt_d = bitcnt_q + 4'd1;
                    end else if (scl_fall && bitcnt_q == 4'd8) begin
                        // ACK is driven from the fall that ends the 8th bit
                        sda_oe_d = 1'b1;
                        state_d  = S_D_ACK;
                        if (state_q == S_ADDR) begin
                            if (shift_q[7:1] == DEV_ADDR) begin
                                state_d = S_A_ACK;
                            end else begin
                                sda_oe_d = 1'b0;
                                busy_d   = 1'b0;
                                state_d  = S_IDLE;
                            end
                        end else if (state_q == S_REG) begin
                            ptr_d = shift_q;
                        end else begin
                            if (ptr_q == 8'h6B) pwr_d = shift_q;
                            ptr_d = ptr_q + 8'd1;
                        end
                    end
                end
                S_A_ACK: begin
                    if (scl_fall) begin
                        bitcnt_d = 4'd0;
                        sda_oe_d = 1'b0;
                        state_d  = S_REG;
                        if (shift_q[0]) begin
                            shadow_d = {accel_x, accel_y, accel_z};
                            tx_d     = rd_byte(ptr_q, {accel_x, accel_y, accel_z}, pwr_q);
                            sda_oe_d = ~tx_d[7];
                            state_d  = S_RDATA;
                        end
                    end
                end
                S_D_ACK: begin
                    if (scl_fall) begin
                        bitcnt_d = 4'd0;
                        sda_oe_d = 1'b0;
                        state_d  = S_WDATA;
                    end
                end
                S_RDATA: begin
                    if (scl_fall) begin
                        if (bitcnt_q == 4'd7) begin
                            sda_oe_d = 1'b0;
                            ptr_d    = ptr_q + 8'd1;
                            state_d  = S_M_ACK;
                        end else begin
                            tx_d     = {tx_q[6:0], 1'b0};
                            sda_oe_d = ~tx_q[6];
                            bitcnt_d = bitcnt_q + 4'd1;
                        end
                    end
                end
                S_M_ACK: begin
                    if (scl_rise) state_d = sda_sync_q ? S_WAIT : S_M_NEXT;
                end
                S_M_NEXT: begin
                    if (scl_fall) begin
                        tx_d     = rd_byte(ptr_q, shadow_q, pwr_q);
                        sda_oe_d = ~tx_d[7];
                        bitcnt_d = 4'd0;
                        state_d  = S_RDATA;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            scl_meta_q <= 1'b1;
            scl_sync_q <= 1'b1;
            scl_prev_q <= 1'b1;
            sda_meta_q <= 1'b1;
            sda_sync_q <= 1'b1;
            sda_prev_q <= 1'b1;
            state_q    <= S_IDLE;
            bitcnt_q   <= 4'd0;
            ptr_q      <= 8'h00;
            pwr_q      <= PWR_RST_VAL;
            sda_oe_q   <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            scl_meta_q <= scl_in;
            scl_sync_q <= scl_meta_q;
            scl_prev_q <= scl_sync_q;
            sda_meta_q <= sda_in;
            sda_sync_q <= sda_meta_q;
            sda_prev_q <= sda_sync_q;
            state_q    <= state_d;
            bitcnt_q   <= bitcnt_d;
            ptr_q      <= ptr_d;
            pwr_q      <= pwr_d;
            sda_oe_q   <= sda_oe_d;
            busy_q     <= busy_d;
        end
        shift_q  <= shift_d;
        tx_q     <= tx_d;
        shadow_q <= shadow_d;
    end

    assign sda_oe     = sda_oe_q;
    assign busy       = busy_q;
    assign pwr_mgmt_1 = pwr_q;

endmodule

// File: tb/tb_mpu6050_i2c_responder.sv
// Bench for mpu6050_i2c_responder: a bit-banged I2C master plus a register-map model.
module tb_mpu6050_i2c_responder;

    localparam int Q = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        scl_m = 1'b1;
    logic        sda_m = 1'b1;
    logic        sda_oe;
    logic [15:0] ax = 16'h0, ay = 16'h0, az = 16'h0;
    logic [7:0]  pwr;
    logic        busy;
    wire         sda_bus = sda_m & ~sda_oe;

    int          checks = 0;
    int          passes = 0;
    logic [7:0]  pwr_m = 8'h40;
    logic        ack_q[$];
    logic [7:0]  rd_q[$];

    mpu6050_i2c_responder dut (
        .clk       (clk),
        .rst       (rst),
        .scl_in    (scl_m),
        .sda_in    (sda_bus),
        .sda_oe    (sda_oe),
        .accel_x   (ax),
        .accel_y   (ay),
        .accel_z   (az),
        .pwr_mgmt_1(pwr),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #900000;
        $display("FAIL watchdog: run did not finish, checks=%0d", checks);
        $fatal(1);
    end

    // Register map as seen by the master, from the snapshot taken at the read address
    function automatic logic [7:0] model_byte(input logic [7:0] a, input logic [15:0] x,
                                              input logic [15:0] y, input logic [15:0] z,
                                              input logic [7:0] p);
        logic [7:0] accel [6];
        accel = '{x[15:8], x[7:0], y[15:8], y[7:0], z[15:8], z[7:0]};
        if (a >= 8'h3B && a <= 8'h40) return accel[a - 8'h3B];
        if (a == 8'h6B) return p;
        if (a == 8'h75) return 8'h68;
        return 8'h00;
    endfunction

    task automatic qwait();
        repeat (Q) @(negedge clk);
    endtask

    task automatic bus_start();
        sda_m = 1'b1; qwait();
        scl_m = 1'b1; qwait();
        sda_m = 1'b0; qwait();
        scl_m = 1'b0; qwait();
    endtask

    task automatic bus_stop();
        sda_m = 1'b0; qwait();
        scl_m = 1'b1; qwait();
        sda_m = 1'b1; qwait();
    endtask

    task automatic send_byte(input logic [7:0] b, output logic acked);
        for (int i = 7; i >= 0; i--) begin
            sda_m = b[i]; qwait();
            scl_m = 1'b1; qwait(); qwait();
            scl_m = 1'b0; qwait();
        end
        sda_m = 1'b1; qwait();
        scl_m = 1'b1; qwait();
        acked = ~sda_bus; qwait();
        scl_m = 1'b0; qwait();
    endtask

    task automatic recv_byte(input logic nack, output logic [7:0] b);
        for (int i = 7; i >= 0; i--) begin
            sda_m = 1'b1; qwait();
            scl_m = 1'b1; qwait();
            b[i] = sda_bus; qwait();
            scl_m = 1'b0; qwait();
        end
        sda_m = nack; qwait();
        scl_m = 1'b1; qwait(); qwait();
        scl_m = 1'b0; qwait();
        sda_m = 1'b1;
    endtask

    task automatic read_regs(input logic [7:0] a, input int n);
        logic       ack;
        logic [7:0] b;
        ack_q.delete();
        rd_q.delete();
        bus_start();
        send_byte(8'hD0, ack); ack_q.push_back(ack);
        send_byte(a, ack);     ack_q.push_back(ack);
        bus_start();
        send_byte(8'hD1, ack); ack_q.push_back(ack);
        for (int i = 0; i < n; i++) begin
            recv_byte(i == n - 1, b);
            rd_q.push_back(b);
        end
        bus_stop();
    endtask

    task automatic write_regs(input logic [7:0] a, input logic [15:0] d, input int n);
        logic ack;
        ack_q.delete();
        bus_start();
        send_byte(8'hD0, ack); ack_q.push_back(ack);
        send_byte(a, ack);     ack_q.push_back(ack);
        if (n == 2) begin
            send_byte(d[15:8], ack); ack_q.push_back(ack);
        end
        send_byte(d[7:0], ack); ack_q.push_back(ack);
        bus_stop();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (sda_oe !== 1'b0) $display("FAIL reset_sda_oe: got %b expected 0", sda_oe); else passes++;
        checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else passes++;
        checks++; if (pwr !== 8'h40) $display("FAIL reset_pwr: got %h expected 40", pwr); else passes++;
        rst = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_who_am_i();
        logic       ack;
        logic [7:0] b;
        bus_start();
        checks++; if (busy !== 1'b1) $display("FAIL who_busy_start: got %b expected 1", busy); else passes++;
        send_byte(8'hD0, ack);
        checks++; if (ack !== 1'b1) $display("FAIL who_ack_addr_w: got %b expected 1", ack); else passes++;
        send_byte(8'h75, ack);
        checks++; if (ack !== 1'b1) $display("FAIL who_ack_reg: got %b expected 1", ack); else passes++;
        bus_start();
        send_byte(8'hD1, ack);
        checks++; if (ack !== 1'b1) $display("FAIL who_ack_addr_r: got %b expected 1", ack); else passes++;
        recv_byte(1'b1, b);
        checks++; if (b !== model_byte(8'h75, ax, ay, az, pwr_m))
            $display("FAIL who_data: got %h expected %h", b, model_byte(8'h75, ax, ay, az, pwr_m)); else passes++;
        bus_stop();
        checks++; if (busy !== 1'b0) $display("FAIL who_busy_stop: got %b expected 0", busy); else passes++;
    endtask

    task automatic test_burst();
        logic [15:0] x, y, z;
        logic [7:0]  a, e;
        ax = 16'h1234; ay = 16'hFF80; az = 16'h4000;
        read_regs(8'h3B, 6);
        for (int i = 0; i < 6; i++) begin
            e = model_byte(8'h3B + 8'(i), 16'h1234, 16'hFF80, 16'h4000, pwr_m);
            checks++; if (rd_q[i] !== e) $display("FAIL burst_fixed[%0d]: got %h expected %h", i, rd_q[i], e); else passes++;
        end
        for (int k = 0; k < 3; k++) begin
            x = 16'($urandom); y = 16'($urandom); z = 16'($urandom);
            ax = x; ay = y; az = z;
            a = 8'h3A + 8'($urandom_range(0, 4));
            read_regs(a, 4);
            for (int i = 0; i < 4; i++) begin
                e = model_byte(a + 8'(i), x, y, z, pwr_m);
                checks++; if (rd_q[i] !== e) $display("FAIL burst_rand[%0d.%0d]: got %h expected %h", k, i, rd_q[i], e); else passes++;
            end
        end
    endtask

    task automatic test_snapshot();
        logic       ack;
        logic [7:0] b, e;
        logic [15:0] y, z;
        y = 16'($urandom); z = 16'($urandom);
        ax = 16'h1234; ay = y; az = z;
        bus_start();
        send_byte(8'hD0, ack);
        send_byte(8'h3B, ack);
        bus_start();
        send_byte(8'hD1, ack);
        for (int i = 0; i < 6; i++) begin
            recv_byte(i == 5, b);
            if (i == 0) begin
                ax = 16'hAAAA; ay = ~y; az = ~z;
            end
            e = model_byte(8'h3B + 8'(i), 16'h1234, y, z, pwr_m);
            checks++; if (b !== e) $display("FAIL snapshot[%0d]: got %h expected %h", i, b, e); else passes++;
        end
        bus_stop();
    endtask

    task automatic test_pwr_write();
        logic       ack;
        logic [7:0] v, w;
        v = 8'($urandom);
        write_regs(8'h10, {8'h00, v}, 1);
        checks++; if (pwr !== pwr_m) $display("FAIL pwr_other_reg: got %h expected %h", pwr, pwr_m); else passes++;
        w = 8'($urandom);
        write_regs(8'h6A, {v, w}, 2);
        pwr_m = w;
        foreach (ack_q[i]) begin
            checks++; if (ack_q[i] !== 1'b1) $display("FAIL pwr_ack[%0d]: got %b expected 1", i, ack_q[i]); else passes++;
        end
        checks++; if (pwr !== pwr_m) $display("FAIL pwr_incr_write: got %h expected %h", pwr, pwr_m); else passes++;
        read_regs(8'h6B, 1);
        checks++; if (rd_q[0] !== pwr_m) $display("FAIL pwr_readback_rand: got %h expected %h", rd_q[0], pwr_m); else passes++;
        bus_start();
        send_byte(8'hD0, ack);
        send_byte(8'h6B, ack);
        send_byte(8'h00, ack);
        pwr_m = 8'h00;
        checks++; if (pwr !== pwr_m) $display("FAIL pwr_at_ack: got %h expected %h", pwr, pwr_m); else passes++;
        bus_stop();
        read_regs(8'h6B, 1);
        checks++; if (rd_q[0] !== pwr_m) $display("FAIL pwr_readback_zero: got %h expected %h", rd_q[0], pwr_m); else passes++;
    endtask

    task automatic test_bad_addr();
        logic ack;
        bus_start();
        send_byte(8'hA0, ack);
        checks++; if (ack !== 1'b0) $display("FAIL bad_addr_ack: got %b expected 0", ack); else passes++;
        checks++; if (sda_oe !== 1'b0) $display("FAIL bad_addr_oe: got %b expected 0", sda_oe); else passes++;
        bus_stop();
        checks++; if (busy !== 1'b0) $display("FAIL bad_addr_busy: got %b expected 0", busy); else passes++;
    endtask

    task automatic test_reset_mid();
        logic ack;
        ax = 16'h1234;
        bus_start();
        send_byte(8'hD0, ack);
        send_byte(8'h3B, ack);
        bus_start();
        send_byte(8'hD1, ack);
        checks++; if (sda_oe !== 1'b1) $display("FAIL rstmid_driving: got %b expected 1", sda_oe); else passes++;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (sda_oe !== 1'b0) $display("FAIL rstmid_oe: got %b expected 0", sda_oe); else passes++;
        checks++; if (pwr !== 8'h40) $display("FAIL rstmid_pwr: got %h expected 40", pwr); else passes++;
        checks++; if (busy !== 1'b0) $display("FAIL rstmid_busy: got %b expected 0", busy); else passes++;
        @(negedge clk);
        rst = 1'b0;
        pwr_m = 8'h40;
        repeat (4) @(negedge clk);
        read_regs(8'h75, 1);
        foreach (ack_q[i]) begin
            checks++; if (ack_q[i] !== 1'b1) $display("FAIL rstmid_ack[%0d]: got %b expected 1", i, ack_q[i]); else passes++;
        end
        checks++; if (rd_q[0] !== 8'h68) $display("FAIL rstmid_data: got %h expected 68", rd_q[0]); else passes++;
    endtask

    task automatic test_wrap();
        read_regs(8'hFF, 2);
        for (int i = 0; i < 2; i++) begin
            checks++; if (rd_q[i] !== 8'h00) $display("FAIL wrap[%0d]: got %h expected 00", i, rd_q[i]); else passes++;
        end
    endtask

    task automatic test_random_reads();
        logic [15:0] x, y, z;
        logic [7:0]  a, e;
        int          n;
        for (int k = 0; k < 8; k++) begin
            x = 16'($urandom); y = 16'($urandom); z = 16'($urandom);
            ax = x; ay = y; az = z;
            case ($urandom_range(0, 5))
                0: a = 8'h3B + 8'($urandom_range(0, 5));
                1: a = 8'h6A;
                2: a = 8'h6B;
                3: a = 8'h74;
                4: a = 8'h75;
                default: a = 8'($urandom);
            endcase
            n = $urandom_range(1, 3);
            read_regs(a, n);
            for (int i = 0; i < n; i++) begin
                e = model_byte(a + 8'(i), x, y, z, pwr_m);
                checks++; if (rd_q[i] !== e) $display("FAIL rand_read[%0d.%0d] @%h: got %h expected %h", k, i, a + 8'(i), rd_q[i], e); else passes++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_who_am_i();
        test_burst();
        test_snapshot();
        test_pwr_write();
        test_bad_addr();
        test_reset_mid();
        test_wrap();
        test_random_reads();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
